// File: rtl/arbiter_pkg.sv
// Shared definitions for the round-robin arbiter slice: FSM states and
// the default data width.
package arbiter_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_1 = 2'd1,
    LOCK_2 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mux_2x1.sv
// Plain combinational 2:1 data multiplexer; SELECT=0 picks input 1.
module mux_2x1 #(
  parameter int WIDTH = 32
) (
  input  logic             SELECT,
  input  logic [WIDTH-1:0] DATA_IN_1,
  input  logic [WIDTH-1:0] DATA_IN_2,
  output logic [WIDTH-1:0] DATA_OUT
);

  // Pure data steering, no gating on the data values themselves.
  always_comb begin
    DATA_OUT = SELECT ? DATA_IN_2 : DATA_IN_1;
  end

endmodule

// File: rtl/rr_arbiter_2x1.sv
// Two-requester round-robin packet arbiter with a registered output stage.
// A grant is locked to one requester from its first non-LAST beat until its
// LAST beat is accepted; the priority pointer flips after every LAST beat.
module rr_arbiter_2x1
  import arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ_VALID_1,
  input  logic             REQ_VALID_2,
  input  logic [WIDTH-1:0] DATA_IN_1,
  input  logic [WIDTH-1:0] DATA_IN_2,
  input  logic             REQ_LAST_1,
  input  logic             REQ_LAST_2,
  output logic             READY_1,
  output logic             READY_2,
  output logic             SELECT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             OUT_LAST,
  output logic             OUT_SRC
);

  arb_state_e       state_q;
  arb_state_e       state_d;
  logic             prio_q;
  logic             select_q;
  logic             grant_sel;
  logic             grant_any;
  logic             can_accept;
  logic             accept;
  logic             last_sel;
  logic [WIDTH-1:0] mux_data;

  mux_2x1 #(
    .WIDTH(WIDTH)
  ) u_mux (
    .SELECT   (SELECT),
    .DATA_IN_1(DATA_IN_1),
    .DATA_IN_2(DATA_IN_2),
    .DATA_OUT (mux_data)
  );

  // Grant decision, handshake and next-state logic; SELECT and READY are
  // forced low while reset is held so nothing is offered during reset.
  always_comb begin
    grant_sel = select_q;
    grant_any = 1'b0;
    state_d   = state_q;
    case (state_q)
      IDLE: begin
        if (REQ_VALID_1 && REQ_VALID_2) begin
          grant_sel = prio_q;
          grant_any = 1'b1;
        end else if (REQ_VALID_1) begin
          grant_sel = 1'b0;
          grant_any = 1'b1;
        end else if (REQ_VALID_2) begin
          grant_sel = 1'b1;
          grant_any = 1'b1;
        end
      end
      LOCK_1: begin
        grant_sel = 1'b0;
        grant_any = 1'b1;
      end
      LOCK_2: begin
        grant_sel = 1'b1;
        grant_any = 1'b1;
      end
      default: begin
        grant_sel = select_q;
        grant_any = 1'b0;
      end
    endcase

    can_accept = !OUT_VALID || OUT_READY;
    SELECT     = RST_N && grant_sel;
    READY_1    = RST_N && grant_any && !grant_sel && can_accept;
    READY_2    = RST_N && grant_any && grant_sel && can_accept;
    accept     = (READY_1 && REQ_VALID_1) || (READY_2 && REQ_VALID_2);
    last_sel   = grant_sel ? REQ_LAST_2 : REQ_LAST_1;

    case (state_q)
      IDLE: begin
        if (accept && !last_sel) begin
          state_d = grant_sel ? LOCK_2 : LOCK_1;
        end
      end
      LOCK_1, LOCK_2: begin
        if (accept && last_sel) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, priority pointer and remembered grant for idle cycles.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      select_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      select_q <= grant_sel;
      if (accept && last_sel) begin
        prio_q <= ~grant_sel;
      end
    end
  end

  // Output register: load on accept, drain on consume, hold under backpressure.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT_VALID <= 1'b0;
      DATA_OUT  <= '0;
      OUT_LAST  <= 1'b0;
      OUT_SRC   <= 1'b0;
    end else if (accept) begin
      OUT_VALID <= 1'b1;
      DATA_OUT  <= mux_data;
      OUT_LAST  <= last_sel;
      OUT_SRC   <= grant_sel;
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_2x1.sv
// Scoreboard bench for rr_arbiter_2x1: directed stimulus pushes expected
// output beats, a monitor pops and compares every consumed beat.
module tb_rr_arbiter_2x1;

  localparam int WIDTH = 32;

  logic             CLK;
  logic             RST_N;
  logic             REQ_VALID_1;
  logic             REQ_VALID_2;
  logic [WIDTH-1:0] DATA_IN_1;
  logic [WIDTH-1:0] DATA_IN_2;
  logic             REQ_LAST_1;
  logic             REQ_LAST_2;
  logic             READY_1;
  logic             READY_2;
  logic             SELECT;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] DATA_OUT;
  logic             OUT_LAST;
  logic             OUT_SRC;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH+1:0] exp_q[$];

  rr_arbiter_2x1 #(
    .WIDTH(WIDTH)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .REQ_VALID_1(REQ_VALID_1),
    .REQ_VALID_2(REQ_VALID_2),
    .DATA_IN_1  (DATA_IN_1),
    .DATA_IN_2  (DATA_IN_2),
    .REQ_LAST_1 (REQ_LAST_1),
    .REQ_LAST_2 (REQ_LAST_2),
    .READY_1    (READY_1),
    .READY_2    (READY_2),
    .SELECT     (SELECT),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .DATA_OUT   (DATA_OUT),
    .OUT_LAST   (OUT_LAST),
    .OUT_SRC    (OUT_SRC)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard time bound so the bench can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v1, input logic [WIDTH-1:0] d1, input logic l1,
                               input logic v2, input logic [WIDTH-1:0] d2, input logic l2,
                               input logic ordy);
    @(posedge CLK);
    #1;
    REQ_VALID_1 = v1;
    DATA_IN_1   = d1;
    REQ_LAST_1  = l1;
    REQ_VALID_2 = v2;
    DATA_IN_2   = d2;
    REQ_LAST_2  = l2;
    OUT_READY   = ordy;
  endtask

  task automatic expectBeat(input logic src, input logic last, input logic [WIDTH-1:0] data);
    exp_q.push_back({src, last, data});
  endtask

  // Monitor: every beat the consumer takes must match the head of the queue.
  always @(negedge CLK) begin
    if (RST_N && OUT_VALID && OUT_READY) begin
      logic [WIDTH+1:0] beat;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL beat_unexpected: actual=%0h required=none", {OUT_SRC, OUT_LAST, DATA_OUT});
      end else begin
        beat = exp_q.pop_front();
        if ({OUT_SRC, OUT_LAST, DATA_OUT} !== beat) begin
          failures++;
          $display("[TB] FAIL beat: actual=%0h required=%0h at %0t",
                   {OUT_SRC, OUT_LAST, DATA_OUT}, beat, $time);
        end
      end
    end
  end

  // Directed stimulus sequence.
  initial begin
    RST_N       = 1'b0;
    REQ_VALID_1 = 1'b0;
    REQ_VALID_2 = 1'b1;
    DATA_IN_1   = '0;
    DATA_IN_2   = 32'd9;
    REQ_LAST_1  = 1'b0;
    REQ_LAST_2  = 1'b1;
    OUT_READY   = 1'b0;
    #3;
    checkOutput("rst_out_valid", 32'(OUT_VALID), 32'd0);
    checkOutput("rst_select", 32'(SELECT), 32'd0);
    checkOutput("rst_data_out", DATA_OUT, 32'd0);
    checkOutput("rst_ready_1", 32'(READY_1), 32'd0);
    checkOutput("rst_ready_2", 32'(READY_2), 32'd0);

    // Single requester, single beat.
    applyStimulus(1, 32'd1, 1, 0, 32'd0, 0, 1);
    RST_N = 1'b1;
    @(negedge CLK);
    checkOutput("single_ready_1", 32'(READY_1), 32'd1);
    checkOutput("single_ready_2", 32'(READY_2), 32'd0);
    checkOutput("single_select", 32'(SELECT), 32'd0);
    expectBeat(0, 1, 32'd1);
    applyStimulus(0, 32'd0, 0, 1, 32'd5, 1, 1);
    @(negedge CLK);
    checkOutput("single_out_valid", 32'(OUT_VALID), 32'd1);
    checkOutput("single_data_out", DATA_OUT, 32'd1);
    checkOutput("single_out_src", 32'(OUT_SRC), 32'd0);
    checkOutput("req2_select", 32'(SELECT), 32'd1);
    expectBeat(1, 1, 32'd5);

    // Contention with single-beat packets: grants alternate 1,2,1,2.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 32'd1, 1, 1, 32'd2, 1, 1);
      @(negedge CLK);
      checkOutput("contend_select", 32'(SELECT), 32'(i % 2));
      expectBeat(1'(i % 2), 1, (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    applyStimulus(0, 32'd0, 0, 0, 32'd0, 0, 1);

    // Packet lock: requester 2 holds the grant for 3 beats.
    applyStimulus(0, 32'd0, 0, 1, 32'd10, 0, 1);
    @(negedge CLK);
    checkOutput("lock_first_ready_2", 32'(READY_2), 32'd1);
    expectBeat(1, 0, 32'd10);
    applyStimulus(1, 32'd20, 1, 1, 32'd11, 0, 1);
    @(negedge CLK);
    checkOutput("lock_mid_ready_1", 32'(READY_1), 32'd0);
    checkOutput("lock_mid_select", 32'(SELECT), 32'd1);
    expectBeat(1, 0, 32'd11);
    applyStimulus(1, 32'd20, 1, 1, 32'd12, 1, 1);
    @(negedge CLK);
    checkOutput("lock_last_ready_1", 32'(READY_1), 32'd0);
    checkOutput("lock_last_ready_2", 32'(READY_2), 32'd1);
    expectBeat(1, 1, 32'd12);
    applyStimulus(1, 32'd20, 1, 0, 32'd0, 0, 1);
    @(negedge CLK);
    checkOutput("unlock_ready_1", 32'(READY_1), 32'd1);
    checkOutput("unlock_select", 32'(SELECT), 32'd0);
    expectBeat(0, 1, 32'd20);
    applyStimulus(0, 32'd0, 0, 0, 32'd0, 0, 1);

    // Backpressure: output held for 4 cycles, then drain plus refill.
    applyStimulus(1, 32'd30, 1, 0, 32'd0, 0, 1);
    expectBeat(0, 1, 32'd30);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 32'd31, 1, 0, 32'd0, 0, 0);
      @(negedge CLK);
      checkOutput("bp_data_hold", DATA_OUT, 32'd30);
      checkOutput("bp_ready_1", 32'(READY_1), 32'd0);
      checkOutput("bp_out_valid", 32'(OUT_VALID), 32'd1);
    end
    applyStimulus(1, 32'd31, 1, 0, 32'd0, 0, 1);
    @(negedge CLK);
    checkOutput("bp_release_ready_1", 32'(READY_1), 32'd1);
    expectBeat(0, 1, 32'd31);
    applyStimulus(0, 32'd0, 0, 0, 32'd0, 0, 1);
    @(negedge CLK);
    checkOutput("bp_next_valid", 32'(OUT_VALID), 32'd1);
    checkOutput("bp_next_data", DATA_OUT, 32'd31);
    applyStimulus(0, 32'd0, 0, 0, 32'd0, 0, 1);

    // Reset while locked to requester 2: the in-flight beat is discarded.
    applyStimulus(0, 32'd0, 0, 1, 32'd40, 0, 1);
    applyStimulus(1, 32'd50, 1, 1, 32'd41, 0, 0);
    #1;
    checkOutput("pre_rst_select", 32'(SELECT), 32'd1);
    #1;
    RST_N = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(OUT_VALID), 32'd0);
    checkOutput("midrst_select", 32'(SELECT), 32'd0);
    checkOutput("midrst_ready_2", 32'(READY_2), 32'd0);
    applyStimulus(1, 32'd50, 1, 1, 32'd60, 1, 1);
    RST_N = 1'b1;
    @(negedge CLK);
    checkOutput("post_rst_select", 32'(SELECT), 32'd0);
    checkOutput("post_rst_ready_1", 32'(READY_1), 32'd1);
    checkOutput("post_rst_ready_2", 32'(READY_2), 32'd0);
    expectBeat(0, 1, 32'd50);
    applyStimulus(0, 32'd0, 0, 1, 32'd60, 1, 1);
    @(negedge CLK);
    checkOutput("post_rst_second_select", 32'(SELECT), 32'd1);
    expectBeat(1, 1, 32'd60);
    applyStimulus(0, 32'd0, 0, 0, 32'd0, 0, 1);
    applyStimulus(0, 32'd0, 0, 0, 32'd0, 0, 1);
    applyStimulus(0, 32'd0, 0, 0, 32'd0, 0, 1);
    @(negedge CLK);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
